decode_stage: RTL
=================

Name: decode_stage

Overview:
RV32I instruction-decode stage that sits directly upstream of register_file.
- Holds the IF/ID pipeline register and drives the register_file read addresses (A1/A2).
- Resolves operands from RD1/RD2, MEM/WB forwarding and x0 forcing.
- Detects read-after-write hazards and stalls; generates immediates and control.
- Launches the ID/EX pipeline register toward the execute stage.

Parameters:
FWD_EN, 1, 1 = forward from MEM/WB; 0 = stall on any in-flight match instead.
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  branch/exception flush from execute
if_valid  in  1  fetch presents an instruction
if_instr  in  32  instruction word
if_pc  in  32  instruction PC
id_ready  out  1  IF/ID accepts this cycle
rf_a1  out  5  register_file A1 (rs1)
rf_a2  out  5  register_file A2 (rs2)
rf_rd1  in  32  register_file RD1
rf_rd2  in  32  register_file RD2
ex_rd  in  5  destination of instruction in EX
ex_regwrite  in  1  EX instruction writes rd
mem_rd  in  5  destination in MEM
mem_regwrite  in  1  MEM instruction writes rd
mem_memread  in  1  MEM instruction is a load (result not ready)
mem_result  in  32  MEM ALU result
wb_rd  in  5  register_file A3
wb_regwrite  in  1  register_file WE
wb_result  in  32  register_file WD3
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_pc  out  32  PC
id_ex_rs1_val  out  32  resolved rs1 operand
id_ex_rs2_val  out  32  resolved rs2 operand
id_ex_imm  out  32  sign-extended immediate
id_ex_rd  out  5  destination register
id_ex_alu_op  out  4  ALU operation code (package enum)
id_ex_ctrl  out  6  {regwrite, memread, memwrite, branch, jump, alusrc}
id_ex_illegal  out  1  unsupported opcode

Behaviour:
Reset:
- Both valids, all ID/EX outputs and all IF/ID contents are 0 on the first edge with rst=1.
- rf_a1/rf_a2 = 0 while IF/ID is invalid.

Addressing and operand resolution:
- rf_a1 = IF/ID instr[19:15]; rf_a2 = instr[24:20]; both combinational from the IF/ID register.
- Only rs fields actually used by the opcode count: U/J types use none; I-type uses rs1 only.
- Operand priority: rs==0 -> 0; MEM match (mem_regwrite, mem_rd==rs) -> mem_result; WB match (wb_regwrite, wb_rd==rs) -> wb_result; else rf_rd*.
- WB bypass is mandatory: register_file writes at the edge, so same-cycle reads return the stale value.

Stall (combinational) when IF/ID valid and a used rs!=0 matches any of:
- ex_regwrite && ex_rd;
- mem_regwrite && mem_memread && mem_rd;
- if FWD_EN=0, also any MEM or WB writer.

id_ready:
- id_ready = !ifid_valid || !stall.

Per clock edge, priority order:
1. rst.
2. flush: both valids <- 0; a simultaneous if_valid is dropped.
3. stall: IF/ID holds; ID/EX loads a bubble (valid=0, ctrl=0, other fields don't-care).
4. Otherwise:
   - ID/EX <- decoded IF/ID contents (valid = ifid_valid).
   - IF/ID <- if_instr/if_pc with valid = if_valid.

Decode:
- Opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Any other opcode: illegal=1, ctrl=0, valid passes through.
- Immediates:
  - I: [31:20] sign-extended.
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- id_ex_rd is forced to 0 when regwrite=0.

Boundary cases:
- Stall persisting N cycles emits N bubbles and no duplicates.
- Reset mid-stall discards the held instruction.

Decomposition:
Package riscv_pkg:
- Opcode constants.
- alu_op_e enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, COPY_B.
- Control-bit index constants.
- imm_type_e.

Sub-module imm_gen (combinational: instr, imm_type -> imm). The hazard/forward logic stays inline.

Test Plan:
1. Reset then addi x1,x0,5 (0x00500093) with if_valid=1 -> two edges later id_ex_valid=1, imm=5, rd=1, alu_op=ADD, ctrl regwrite=1, alusrc=1, rs1_val=0.
2. add x3,x1,x2 with mem_rd=1 (mem_result=0xA) and wb_rd=2 (wb_result=0xB) both writing, rf_rd1/2=0xFFFF -> rs1_val=0xA, rs2_val=0xB.
3. add x3,x1,x2 with ex_regwrite=1, ex_rd=1 -> id_ready=0, one bubble (id_ex_valid=0); drop ex_regwrite -> instruction issues next edge.
4. Load in MEM (mem_memread=1, mem_rd=5) with ID using x5 -> stall; instruction issues once mem_memread falls, taking the WB value 0x1234 via bypass.
5. flush asserted during a stall with if_valid=1 -> next cycle both valids 0, id_ready=1.
6. Opcode 0x7F -> id_ex_illegal=1, ctrl=0, rd=0; beq imm -8 (0xFE000CE3) -> imm=0xFFFFFFF8.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control-bit positions, ALU and immediate encodings.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Bit positions inside the 6-bit control word {regwrite, memread, memwrite, branch, jump, alusrc}.
  localparam int CTRL_W        = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_JUMP     = 1;
  localparam int CTRL_ALUSRC   = 0;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_COPY_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  // instr[30] selects SUB only for register-register ops; for shifts it selects SRA in both forms.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt,
                                         input logic is_reg);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the RV32I immediate for the given format.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] i_instr,
  input  imm_type_e   i_imm_type,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_imm_type)
      IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      IMM_U:   o_imm = {i_instr[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register-file addressing, operand bypass,
// RAW hazard stall, control/immediate decode and the ID/EX launch register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_val,
  output logic [XLEN-1:0] id_ex_rs2_val,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rd,
  output logic [3:0]      id_ex_alu_op,
  output logic [5:0]      id_ex_ctrl,
  output logic            id_ex_illegal
);

  logic              r_ifid_valid;
  logic [31:0]       r_ifid_instr;
  logic [XLEN-1:0]   r_ifid_pc;

  logic              r_idex_valid;
  logic [XLEN-1:0]   r_idex_pc;
  logic [XLEN-1:0]   r_idex_rs1_val;
  logic [XLEN-1:0]   r_idex_rs2_val;
  logic [XLEN-1:0]   r_idex_imm;
  logic [4:0]        r_idex_rd;
  alu_op_e           r_idex_alu_op;
  logic [CTRL_W-1:0] r_idex_ctrl;
  logic              r_idex_illegal;

  logic [6:0]        w_opcode;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic [CTRL_W-1:0] w_ctrl;
  logic [CTRL_W-1:0] w_ctrl_gated;
  alu_op_e           w_alu_op;
  imm_type_e         w_imm_type;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_illegal;
  logic [31:0]       w_imm;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;
  logic              w_stall;

  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [4:0] rs, input logic [XLEN-1:0] rf_val,
    input logic m_we, input logic [4:0] m_dst, input logic [XLEN-1:0] m_val,
    input logic b_we, input logic [4:0] b_dst, input logic [XLEN-1:0] b_val);
    if (rs == 5'd0)                return '0;
    else if (m_we && m_dst == rs)  return m_val;
    else if (b_we && b_dst == rs)  return b_val;
    else                           return rf_val;
  endfunction

  // Without forwarding every in-flight writer blocks; with it only EX and a pending load do.
  function automatic logic rs_hazard(
    input logic [4:0] rs, input logic e_we, input logic [4:0] e_dst,
    input logic m_we, input logic m_ld, input logic [4:0] m_dst,
    input logic b_we, input logic [4:0] b_dst, input logic fwd);
    logic hit;
    hit = (e_we && e_dst == rs) || (m_we && m_ld && m_dst == rs);
    if (!fwd) hit = hit || (m_we && m_dst == rs) || (b_we && b_dst == rs);
    return (rs != 5'd0) && hit;
  endfunction

  assign w_opcode = r_ifid_instr[6:0];
  assign w_rd     = r_ifid_instr[11:7];
  assign w_rs1    = r_ifid_instr[19:15];
  assign w_rs2    = r_ifid_instr[24:20];

  assign rf_a1 = r_ifid_valid ? w_rs1 : 5'd0;
  assign rf_a2 = r_ifid_valid ? w_rs2 : 5'd0;

  always_comb begin
    w_ctrl     = '0;
    w_alu_op   = ALU_ADD;
    w_imm_type = IMM_NONE;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_alu_op              = ALU_LUI;
        w_imm_type            = IMM_U;
      end
      OPC_AUIPC: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_imm_type            = IMM_U;
      end
      OPC_JAL: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_JUMP]     = 1'b1;
        w_imm_type            = IMM_J;
      end
      OPC_JALR: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_JUMP]     = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_imm_type            = IMM_I;
        w_use_rs1             = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl[CTRL_BRANCH] = 1'b1;
        w_alu_op            = ALU_SUB;
        w_imm_type          = IMM_B;
        w_use_rs1           = 1'b1;
        w_use_rs2           = 1'b1;
      end
      OPC_LOAD: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_MEMREAD]  = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_imm_type            = IMM_I;
        w_use_rs1             = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl[CTRL_MEMWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_imm_type            = IMM_S;
        w_use_rs1             = 1'b1;
        w_use_rs2             = 1'b1;
      end
      OPC_OPIMM: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_alu_op              = alu_decode(r_ifid_instr[14:12], r_ifid_instr[30], 1'b0);
        w_imm_type            = IMM_I;
        w_use_rs1             = 1'b1;
      end
      OPC_OP: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_alu_op              = alu_decode(r_ifid_instr[14:12], r_ifid_instr[30], 1'b1);
        w_use_rs1             = 1'b1;
        w_use_rs2             = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .i_instr    (r_ifid_instr[31:7]),
    .i_imm_type (w_imm_type),
    .o_imm      (w_imm)
  );

  // The WB bypass is required: the register file writes on this same edge, so RD1/RD2 are stale.
  assign w_rs1_val = resolve_operand(w_rs1, rf_rd1, mem_regwrite, mem_rd, mem_result,
                                     wb_regwrite, wb_rd, wb_result);
  assign w_rs2_val = resolve_operand(w_rs2, rf_rd2, mem_regwrite, mem_rd, mem_result,
                                     wb_regwrite, wb_rd, wb_result);

  assign w_stall = r_ifid_valid &&
                   ((w_use_rs1 && rs_hazard(w_rs1, ex_regwrite, ex_rd, mem_regwrite, mem_memread,
                                            mem_rd, wb_regwrite, wb_rd, FWD_EN != 0)) ||
                    (w_use_rs2 && rs_hazard(w_rs2, ex_regwrite, ex_rd, mem_regwrite, mem_memread,
                                            mem_rd, wb_regwrite, wb_rd, FWD_EN != 0)));

  assign id_ready     = !r_ifid_valid || !w_stall;
  assign w_ctrl_gated = r_ifid_valid ? w_ctrl : '0;

  // IF/ID and ID/EX pipeline boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_valid   <= 1'b0;
      r_ifid_instr   <= '0;
      r_ifid_pc      <= '0;
      r_idex_valid   <= 1'b0;
      r_idex_pc      <= '0;
      r_idex_rs1_val <= '0;
      r_idex_rs2_val <= '0;
      r_idex_imm     <= '0;
      r_idex_rd      <= '0;
      r_idex_alu_op  <= ALU_ADD;
      r_idex_ctrl    <= '0;
      r_idex_illegal <= 1'b0;
    end else if (flush) begin
      r_ifid_valid   <= 1'b0;
      r_idex_valid   <= 1'b0;
      r_idex_ctrl    <= '0;
      r_idex_illegal <= 1'b0;
    end else if (w_stall) begin
      r_idex_valid   <= 1'b0;
      r_idex_ctrl    <= '0;
      r_idex_illegal <= 1'b0;
    end else begin
      r_ifid_valid   <= if_valid;
      r_ifid_instr   <= if_instr;
      r_ifid_pc      <= if_pc;
      r_idex_valid   <= r_ifid_valid;
      r_idex_pc      <= r_ifid_pc;
      r_idex_rs1_val <= w_rs1_val;
      r_idex_rs2_val <= w_rs2_val;
      r_idex_imm     <= w_imm;
      r_idex_rd      <= w_ctrl_gated[CTRL_REGWRITE] ? w_rd : 5'd0;
      r_idex_alu_op  <= w_alu_op;
      r_idex_ctrl    <= w_ctrl_gated;
      r_idex_illegal <= r_ifid_valid && w_illegal;
    end
  end

  assign id_ex_valid   = r_idex_valid;
  assign id_ex_pc      = r_idex_pc;
  assign id_ex_rs1_val = r_idex_rs1_val;
  assign id_ex_rs2_val = r_idex_rs2_val;
  assign id_ex_imm     = r_idex_imm;
  assign id_ex_rd      = r_idex_rd;
  assign id_ex_alu_op  = r_idex_alu_op;
  assign id_ex_ctrl    = r_idex_ctrl;
  assign id_ex_illegal = r_idex_illegal;

endmodule
